display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000: clock cycles each digit is lit per scan slot (>=1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 2: dead-time cycles before each slot, all digits off (>=1).
REQ-003 SHALL have port clock, input, 1: single rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port load_valid, input, 1: new display value offered.
REQ-006 SHALL have port load_ready, output, 1: shadow register free; transfer when load_valid && load_ready.
REQ-007 SHALL have port load_data, input, 16: four BCD nibbles; [3:0] = digit0 (least significant), [15:12] = digit3.
REQ-008 SHALL have port lz_blank, input, 1: leading-zero blanking enable, sampled every cycle.
REQ-009 SHALL have port bcd_out, output, 4: nibble to the external registered BCD-to-7-segment decoder (1-cycle latency).
REQ-010 SHALL have port digit_en, output, 4: one-hot active-high digit enable, bit i = digit i.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each 4-digit scan.

Function
REQ-012 SHALL implement FSM states BLANK and SHOW; slot index idx cycles 0,1,2,3,0...
REQ-013 On BLANK entry, bcd_out SHALL take active[idx]; digit_en SHALL be 4'b0000 for all BLANK_CYCLES cycles, covering decoder latency.
REQ-014 BLANK SHALL go to SHOW after exactly BLANK_CYCLES cycles; SHOW SHALL last exactly DWELL_CYCLES cycles with digit_en[idx]=1, unless the digit is blanked.
REQ-015 SHOW end SHALL return to BLANK with idx+1 mod 4; one frame = 4*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-016 On the SHOW-to-BLANK transition with idx=3, frame_done SHALL pulse for one cycle.
REQ-017 load_ready SHALL be registered and equal to NOT pending; an accepted transfer SHALL copy load_data into shadow and set pending.
REQ-018 At each frame_done, if pending, shadow SHALL commit to active and pending SHALL clear, so load_ready rises the following cycle.
REQ-019 Updates SHALL never change displayed digits mid-frame (no tearing).
REQ-020 load_valid while load_ready=0 SHALL be ignored, and load_data need not be held.
REQ-021 With lz_blank=1, digit k (k=3..1) SHALL be blanked if active[k] and every higher digit are 0; blanked means digit_en stays 0 in SHOW and bcd_out=4'hF.
REQ-022 digit0 SHALL never be blanked.
REQ-023 Nibbles >9 SHALL pass through unchanged.
REQ-024 The single timer SHALL be $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) bits wide, reload at each state entry, and never wrap.

Reset
REQ-025 While reset_n=0, all state SHALL clear asynchronously: state=BLANK, idx=0, timer=0, active=16'h0000, shadow=0, pending=0.
REQ-026 Reset values SHALL be: digit_en=0, bcd_out=4'h0, frame_done=0, load_ready=0.
REQ-027 load_ready SHALL rise on the first clock after reset release.
REQ-028 Reset mid-frame SHALL discard pending data, and the scan SHALL restart at digit0 BLANK.

Structure
REQ-029 Shared package display_pkg SHALL hold NUM_DIGITS=4, BCD_W=4, BCD_BLANK=4'hF and the state enum {BLANK, SHOW}.
REQ-030 Slot timing SHALL live in one sub-module, scan_timer (load value, start, done pulse).
REQ-031 The decoder SHALL be instantiated by the parent, not inside this block.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-032 Reset then idle: digit_en sequence 0,0,0001x4,0,0,0010x4,...; frame_done every 24 cycles; bcd_out=0.
REQ-033 Load 16'h1234 mid-frame: load_ready drops next cycle; display stays 0000 until frame_done, then digits 4,3,2,1 on idx 0..3; load_ready high again one cycle after commit.
REQ-034 Second load_valid while pending: ignored; the first value is displayed.
REQ-035 lz_blank=1 with 16'h0070: digit3 and digit2 enables stay 0, bcd_out=F in their slots; digit1=7 and digit0=0 lit.
REQ-036 reset_n low during SHOW of idx=2 with pending data: outputs zero immediately; after release, scan restarts at idx=0 and displays 0000.
REQ-037 Nibble 4'hB loaded: bcd_out=B in that slot and the digit is enabled.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed BCD display scanner.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;

    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_word_t;

    // Digit k is suppressed when blanking is enabled and it and every higher digit are zero.
    function automatic logic digit_blanked(input bcd_word_t word,
                                           input logic [IDX_W-1:0] k,
                                           input logic lz);
        logic zero_above;
        zero_above = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (i >= int'(k) && word[i] != '0) begin
                zero_above = 1'b0;
            end
        end
        return lz && (k != '0) && zero_above;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer: counts up from zero after start, flags the last cycle of a load-cycle slot.
module scan_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load,
    output logic             done_c
);

    logic [WIDTH-1:0] count;

    assign done_c = (count == WIDTH'(load - 1'b1));

    // Holds at the terminal count rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (!done_c) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed BCD display scanner with dead-time blanking,
// leading-zero suppression and frame-synchronous (tear-free) value updates.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        lz_blank,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_en,
    output logic        frame_done
);

    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);

    scan_state_t       state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    bcd_word_t         active, active_next, shadow;
    logic              pending, pending_next;
    logic              accept_c;
    logic              slot_done_c;
    logic              frame_end_c;
    logic              blank_c;
    logic [TIMER_W-1:0] timer_load_c;
    logic [BCD_W-1:0]  bcd_next_c;
    logic [NUM_DIGITS-1:0] en_next_c;

    scan_timer #(
        .WIDTH (TIMER_W)
    ) u_scan_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (slot_done_c),
        .load    (timer_load_c),
        .done_c  (slot_done_c)
    );

    // Next-state: slot sequencing, frame-boundary commit of the shadow value, load handshake.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        active_next  = active;
        pending_next = pending;
        frame_end_c  = 1'b0;
        accept_c     = load_valid && load_ready;
        timer_load_c = (state == BLANK) ? TIMER_W'(BLANK_CYCLES) : TIMER_W'(DWELL_CYCLES);

        if (slot_done_c) begin
            case (state)
                BLANK: state_next = SHOW;
                SHOW: begin
                    state_next = BLANK;
                    idx_next   = idx + 1'b1;
                    if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                        frame_end_c = 1'b1;
                        if (pending) begin
                            active_next  = shadow;
                            pending_next = 1'b0;
                        end
                    end
                end
                default: state_next = BLANK;
            endcase
        end

        if (accept_c) begin
            pending_next = 1'b1;
        end

        blank_c    = digit_blanked(active_next, idx_next, lz_blank);
        bcd_next_c = blank_c ? BCD_BLANK : active_next[idx_next];
        en_next_c  = (state_next == SHOW && !blank_c) ? (NUM_DIGITS'(1) << idx_next) : '0;
    end

    // State and registered outputs; the decoder input is valid throughout each dead-time window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BLANK;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            load_ready <= 1'b0;
            bcd_out    <= '0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            active     <= active_next;
            pending    <= pending_next;
            if (accept_c) begin
                shadow <= load_data;
            end
            load_ready <= !pending && !accept_c;
            bcd_out    <= bcd_next_c;
            digit_en   <= en_next_c;
            frame_done <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller against a slot-arithmetic reference model.
module tb_display_scan_controller;

    localparam int unsigned DWELL = 4;
    localparam int unsigned B_CYC = 2;
    localparam int unsigned SLOT  = DWELL + B_CYC;
    localparam int unsigned FRAME = 4 * SLOT;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        lz_blank;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since reset release, displayed/buffered values.
    int          n;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic        m_ready;
    logic        m_lz;

    display_scan_controller #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (B_CYC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .lz_blank   (lz_blank),
        .bcd_out    (bcd_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check_outputs();
        int          q;
        int          k;
        logic        show;
        logic        blanked;
        logic [15:0] upper;
        logic [3:0]  e_bcd;
        logic [3:0]  e_en;
        logic        e_fd;
        q       = n % FRAME;
        k       = q / SLOT;
        show    = (n % SLOT) >= B_CYC;
        upper   = m_active >> (4 * k);
        blanked = m_lz && (k > 0) && (upper == 16'h0);
        e_bcd   = blanked ? 4'hF : upper[3:0];
        e_en    = (show && !blanked) ? 4'(1 << k) : 4'h0;
        e_fd    = (n > 0) && (q == 0);

        checks++;
        assert (digit_en === e_en) else begin
            failures++;
            $error("FAIL digit_en n=%0d observed=%b expected=%b", n, digit_en, e_en);
        end
        checks++;
        assert (bcd_out === e_bcd) else begin
            failures++;
            $error("FAIL bcd_out n=%0d observed=%h expected=%h", n, bcd_out, e_bcd);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            failures++;
            $error("FAIL frame_done n=%0d observed=%b expected=%b", n, frame_done, e_fd);
        end
        checks++;
        assert (load_ready === m_ready) else begin
            failures++;
            $error("FAIL load_ready n=%0d observed=%b expected=%b", n, load_ready, m_ready);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic accept;
        logic commit;
        @(posedge clock);
        n++;
        accept = m_ready && load_valid;
        commit = ((n % FRAME) == 0) && m_pending;
        if (commit) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (accept) begin
            m_shadow  = load_data;
            m_pending = 1'b1;
        end
        m_ready = !m_pending && !commit && !accept;
        m_lz    = lz_blank;
        #1;
        check_outputs();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        n         = 0;
        m_active  = 16'h0;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
        m_ready   = 1'b0;
        m_lz      = 1'b0;
        #1;
        check_outputs();
    endtask

    // Present one value for a single accepted transfer, waiting for the slot to free up.
    task automatic offer(input logic [15:0] d);
        for (int i = 0; i < 2 * FRAME && !m_ready; i++) begin
            step();
        end
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
        load_data  = 16'($urandom);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        lz_blank   = 1'b0;
        #2;
        do_reset();
        #10;
        reset_n = 1'b1;

        // Idle scan of an all-zero value across more than one frame.
        run(FRAME + 8);

        // Mid-frame load, followed by an offer that must be ignored while pending.
        offer(16'h1234);
        load_valid = 1'b1;
        load_data  = 16'h9999;
        run(5);
        load_valid = 1'b0;
        run(2 * FRAME);

        // Leading-zero blanking of the two upper digits.
        lz_blank = 1'b1;
        offer(16'h0070);
        run(2 * FRAME);

        // Out-of-range nibbles pass straight through.
        offer(16'hB0B0);
        run(2 * FRAME);
        lz_blank = 1'b0;
        offer(16'h00B0);
        run(2 * FRAME);

        // Randomized loads and blanking toggles.
        for (int i = 0; i < 600; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                lz_blank = ~lz_blank;
            end
            step();
        end
        load_valid = 1'b0;
        lz_blank   = 1'b0;

        // Reset during the SHOW window of digit 2 with a value still pending.
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != 1; i++) begin
            step();
        end
        offer(16'h4321);
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != 2 * SLOT + B_CYC + 1; i++) begin
            step();
        end
        checks++;
        assert (load_ready === 1'b0) else begin
            failures++;
            $error("FAIL pending_before_reset observed=%b expected=%b", load_ready, 1'b0);
        end
        #2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_outputs();
        end
        #2;
        reset_n = 1'b1;
        run(2 * FRAME + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
